ysyx_23060096_imm_pack: RTL and testbench

Immediate encoder: the inverse of the core's immediate generator. Takes a 32-bit instruction template, a 32-bit immediate and a format code, and scatters the immediate into the RV32 I/U/S/B/J bit positions. It also flags values the format cannot represent. Sits in the trace/patch path (jump-stub and test-instruction injection) behind a two-stage valid/ready pipeline.

---
 rtl/ysyx_23060096_imm_pack_if.sv | 37 +++
 rtl/ysyx_23060096_imm_pack.sv | 149 ++++++++++++++
 tb/tb_ysyx_23060096_imm_pack.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060096_imm_pack_if.sv
// Immediate-encoder request/result bundle.
// master: request source / result sink; slave: the encoder.
interface ysyx_23060096_imm_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_imm;
  logic [2:0]  in_fmt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [2:0]  out_err;

  modport master (
    output in_valid,
    output in_inst,
    output in_imm,
    output in_fmt,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_inst,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_inst,
    input  in_imm,
    input  in_fmt,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_inst,
    output out_err
  );
endinterface

// File: rtl/ysyx_23060096_imm_pack.sv
// RV32 immediate encoder: scatters imm into an I/U/S/B/J template.
// Ports: clk, rstn (async, active-high), bus (slave), err_cnt.
module ysyx_23060096_imm_pack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  ysyx_23060096_imm_pack_if.slave bus,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_U = 3'b001;
  localparam logic [2:0] FMT_S = 3'b010;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  logic             r_s1_valid;
  logic [31:0]      r_s1_inst;
  logic [31:0]      r_s1_imm;
  logic [2:0]       r_s1_fmt;
  logic             r_s2_valid;
  logic [31:0]      r_s2_inst;
  logic [2:0]       r_s2_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic        w_s2_load;
  logic        w_in_ready;
  logic        w_fire_in;
  logic        w_fire_out;
  logic        w_is_i;
  logic        w_is_u;
  logic        w_is_s;
  logic        w_is_b;
  logic        w_is_j;
  logic        w_sx12;
  logic        w_sx13;
  logic        w_sx21;
  logic [31:0] w_pk_inst;
  logic        w_rng;
  logic        w_aln;
  logic        w_rsv;

  // S2 drains or is empty; S1 and the input move with it.
  assign w_s2_load  = !r_s2_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_fire_in  = bus.in_valid && w_in_ready;
  assign w_fire_out = r_s2_valid && bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_inst  = r_s2_inst;
  assign bus.out_err   = r_s2_err;
  assign err_cnt       = r_err_cnt;

  assign w_is_i = (r_s1_fmt == FMT_I);
  assign w_is_u = (r_s1_fmt == FMT_U);
  assign w_is_s = (r_s1_fmt == FMT_S);
  assign w_is_b = (r_s1_fmt == FMT_B);
  assign w_is_j = (r_s1_fmt == FMT_J);

  // imm fits N bits when bits [31:N-1] are all equal.
  assign w_sx12 = (&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]);
  assign w_sx13 = (&r_s1_imm[31:12]) || !(|r_s1_imm[31:12]);
  assign w_sx21 = (&r_s1_imm[31:20]) || !(|r_s1_imm[31:20]);

  always_comb begin
    w_pk_inst = r_s1_inst;
    w_rng     = 1'b0;
    w_aln     = 1'b0;
    w_rsv     = 1'b0;
    unique case (1'b1)
      w_is_i: begin
        w_pk_inst[31:20] = r_s1_imm[11:0];
        w_rng            = !w_sx12;
      end
      w_is_u: begin
        w_pk_inst[31:12] = r_s1_imm[31:12];
        w_aln            = |r_s1_imm[11:0];
      end
      w_is_s: begin
        w_pk_inst[31:25] = r_s1_imm[11:5];
        w_pk_inst[11:7]  = r_s1_imm[4:0];
        w_rng            = !w_sx12;
      end
      w_is_b: begin
        w_pk_inst[31]    = r_s1_imm[12];
        w_pk_inst[30:25] = r_s1_imm[10:5];
        w_pk_inst[11:8]  = r_s1_imm[4:1];
        w_pk_inst[7]     = r_s1_imm[11];
        w_rng            = !w_sx13;
        w_aln            = r_s1_imm[0];
      end
      w_is_j: begin
        w_pk_inst[31]    = r_s1_imm[20];
        w_pk_inst[30:21] = r_s1_imm[10:1];
        w_pk_inst[20]    = r_s1_imm[11];
        w_pk_inst[19:12] = r_s1_imm[19:12];
        w_rng            = !w_sx21;
        w_aln            = r_s1_imm[0];
      end
      default: begin
        w_rsv = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_inst  <= '0;
      r_s1_imm   <= '0;
      r_s1_fmt   <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (w_fire_in) begin
        r_s1_inst <= bus.in_inst;
        r_s1_imm  <= bus.in_imm;
        r_s1_fmt  <= bus.in_fmt;
      end
    end
  end

  // Data only reloads with a valid S1 entry, so a stalled
  // or drained S2 keeps its last result stable.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_s2_valid <= 1'b0;
      r_s2_inst  <= '0;
      r_s2_err   <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_inst <= w_pk_inst;
        r_s2_err  <= {w_rsv, w_aln, w_rng};
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_err_cnt <= '0;
    end else if (w_fire_out && (|r_s2_err)
                 && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_23060096_imm_pack.sv
// Directed bench for the immediate encoder.
// Expected results queue on accept; monitor pops on delivery.
module tb_ysyx_23060096_imm_pack;

  logic        clk;
  logic        rstn;
  logic [15:0] err_cnt;
  int          n_cmp;
  int          n_bad;
  logic [34:0] q[$];

  ysyx_23060096_imm_pack_if bus();

  ysyx_23060096_imm_pack #(.CNT_W(16)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] inst,
                      input logic [31:0] imm,
                      input logic [2:0]  fmt,
                      input logic [31:0] ei,
                      input logic [2:0]  ee);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_imm   = imm;
    bus.in_fmt   = fmt;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", 64'(acc), 64'd1);
    if (acc) q.push_back({ei, ee});
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  // Transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rstn && bus.out_valid && bus.out_ready) begin
      logic [34:0] e;
      chk("sb_nonempty", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_inst", 64'(bus.out_inst), 64'(e[34:3]));
        chk("out_err", 64'(bus.out_err), 64'(e[2:0]));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_imm    = '0;
    bus.in_fmt    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_inst", 64'(bus.out_inst), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    rstn = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // error group
    send(32'h13, 32'd2048, 3'b000, 32'h80000013, 3'b001);
    send(32'h63, 32'd3, 3'b011, 32'h00000163, 3'b010);
    send(32'h12345678, 32'hDEAD, 3'b111,
         32'h12345678, 3'b100);
    drain();
    chk("err_cnt3", 64'(err_cnt), 64'd3);

    // latency
    send(32'h13, 32'hFFFFFFFF, 3'b000, 32'hFFF00013, 3'b000);
    @(negedge clk);
    chk("lat_c1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("lat_c2", 64'(bus.out_valid), 64'd1);
    drain();

    // formats back to back
    send(32'h2023, 32'hFFFFFFFC, 3'b010, 32'hFE002E23, 3'b000);
    send(32'h63, 32'd8, 3'b011, 32'h00000463, 3'b000);
    send(32'h6F, 32'h800, 3'b100, 32'h0010006F, 3'b000);
    send(32'h37, 32'h12345000, 3'b001, 32'h12345037, 3'b000);
    send(32'h37, 32'h12345001, 3'b001, 32'h12345037, 3'b010);
    send(32'h6F, 32'hFFFFFFFE, 3'b100, 32'hFFFFF06F, 3'b000);
    drain();
    chk("err_cnt4", 64'(err_cnt), 64'd4);

    // backpressure
    bus.out_ready = 1'b0;
    send(32'h13, 32'd1, 3'b000, 32'h00100013, 3'b000);
    send(32'h13, 32'd2, 3'b000, 32'h00200013, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold", 64'(bus.out_inst), 64'h00100013);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(32'h13, 32'd3, 3'b000, 32'h00300013, 3'b000);
    send(32'h13, 32'd4, 3'b000, 32'h00400013, 3'b000);
    drain();

    // reset mid-stream
    send(32'h13, 32'd5, 3'b000, 32'h00500013, 3'b000);
    send(32'h13, 32'd6, 3'b000, 32'h00600013, 3'b000);
    chk("mid_valid", 64'(bus.out_valid), 64'd1);
    rstn = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(err_cnt), 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    send(32'h63, 32'hFFFFFFFE, 3'b011, 32'hFE000FE3, 3'b000);
    drain();
    chk("post_rst_cnt", 64'(err_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
